// File: rtl/mem_master.sv
// mem_master: single-outstanding request/response master for a registered
// single-port memory. Each accepted transaction walks IDLE -> ISSUE ->
// CAPTURE -> RESP. Addresses with bit 14 set are IO addresses.
// Optional feature macro: MEM_MASTER_IO_READ_EN. When defined, IO reads
// return the 2-flop synchronized sw_in instead of mem_dout. When undefined,
// there is no synchronizer and IO reads behave like any other read.
// The IO decode uses address bit 14, so ADDR_WIDTH must be at least 15.

module mem_master #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    input  logic [DATA_WIDTH-1:0] sw_in
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t                state_q;
    state_t                state_d;

    logic                  reqWe_q;
    logic [ADDR_WIDTH-1:0] reqAddr_q;
    logic [DATA_WIDTH-1:0] reqWdata_q;
    logic [DATA_WIDTH-1:0] rspRdata_q;

    logic                  acceptEn;
    logic                  captureEn;
    logic [DATA_WIDTH-1:0] captureData;

`ifdef MEM_MASTER_IO_READ_EN
    logic [DATA_WIDTH-1:0] swSync1_q;
    logic [DATA_WIDTH-1:0] swSync2_q;

    // Two-stage synchronizer for the asynchronous switches, running in every state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            swSync1_q <= '0;
            swSync2_q <= '0;
        end else begin
            swSync1_q <= sw_in;
            swSync2_q <= swSync1_q;
        end
    end
`else
    logic unusedSwIn;
    assign unusedSwIn = ^sw_in;
`endif

    // State register; reset aborts whatever transaction is in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fixed one-cycle ISSUE and CAPTURE, RESP waits for rsp_ready
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = ISSUE;
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode: handshakes, write strobe and internal load enables per state
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_we    = 1'b0;
        acceptEn  = 1'b0;
        captureEn = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                acceptEn  = req_valid;
            end
            ISSUE:   mem_we    = reqWe_q;
            CAPTURE: captureEn = 1'b1;
            RESP:    rsp_valid = 1'b1;
            default: req_ready = 1'b0;
        endcase
    end

    // Request registers load only on acceptance, so later req_* changes are ignored
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reqWe_q    <= 1'b0;
            reqAddr_q  <= '0;
            reqWdata_q <= '0;
        end else if (acceptEn) begin
            reqWe_q    <= req_we;
            reqAddr_q  <= req_addr;
            reqWdata_q <= req_wdata;
        end
    end

    // Response source select: echo write data, switches for IO reads, else memory
    always_comb begin
        if (reqWe_q) begin
            captureData = reqWdata_q;
        end
`ifdef MEM_MASTER_IO_READ_EN
        else if (reqAddr_q[14]) begin
            captureData = swSync2_q;
        end
`endif
        else begin
            captureData = mem_dout;
        end
    end

    // Response data register, held from one CAPTURE edge to the next
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rspRdata_q <= '0;
        end else if (captureEn) begin
            rspRdata_q <= captureData;
        end
    end

    assign mem_addr  = reqAddr_q;
    assign mem_din   = reqWdata_q;
    assign rsp_rdata = rspRdata_q;

endmodule

// File: tb/tb_mem_master.sv
// tb_mem_master: directed bench for mem_master with a transaction-level
// reference model and a per-cycle compare process on the falling clock edge.
// Honours MEM_MASTER_IO_READ_EN the same way the design does.

module tb_mem_master;

    localparam int DW = 16;
    localparam int AW = 16;

`ifdef MEM_MASTER_IO_READ_EN
    localparam bit IO_EN = 1'b1;
`else
    localparam bit IO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;
    logic [DW-1:0] sw_in;

    int checks = 0;
    int errors = 0;
    int weCount = 0;

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    mem_master #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_din  (mem_din),
        .mem_dout (mem_dout),
        .sw_in    (sw_in)
    );

    logic [DW-1:0] mem    [0:65535];
    logic [DW-1:0] shadow [0:65535];

    // Registered single-port memory: read-first, data valid the cycle after the address edge
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr];
    end

    // Reference model, tracked as the age of the one outstanding transaction
    logic          mBusy;
    int            mAge;
    logic          mWe;
    logic [AW-1:0] mAddr;
    logic [DW-1:0] mDin;
    logic [DW-1:0] mPending;
    logic [DW-1:0] mRdata;

    // Model update: accept in idle, write lands after one edge, response ready after two
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mBusy    <= 1'b0;
            mAge     <= 0;
            mWe      <= 1'b0;
            mAddr    <= '0;
            mDin     <= '0;
            mPending <= '0;
            mRdata   <= '0;
        end else if (!mBusy) begin
            if (req_valid) begin
                mBusy <= 1'b1;
                mAge  <= 1;
                mWe   <= req_we;
                mAddr <= req_addr;
                mDin  <= req_wdata;
                if (req_we)                   mPending <= req_wdata;
                else if (IO_EN && req_addr[14]) mPending <= sw_in;
                else                          mPending <= shadow[req_addr];
            end
        end else if (mAge == 1) begin
            if (mWe) shadow[mAddr] <= mDin;
            mAge <= 2;
        end else if (mAge == 2) begin
            mRdata <= mPending;
            mAge   <= 3;
        end else if (rsp_ready) begin
            mBusy <= 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        checkOutput("cyc_req_ready", {31'd0, req_ready}, {31'd0, !mBusy});
        checkOutput("cyc_rsp_valid", {31'd0, rsp_valid}, {31'd0, (mBusy && mAge == 3)});
        checkOutput("cyc_mem_we",    {31'd0, mem_we},    {31'd0, (mBusy && mAge == 1 && mWe)});
        checkOutput("cyc_mem_addr",  {16'd0, mem_addr},  {16'd0, mAddr});
        checkOutput("cyc_mem_din",   {16'd0, mem_din},   {16'd0, mDin});
        checkOutput("cyc_rsp_rdata", {16'd0, rsp_rdata}, {16'd0, mRdata});
        if (mem_we === 1'b1) weCount++;
    end

    // One full transaction with rsp_ready held high; call just after a rising edge
    task automatic applyStimulus(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                                 input logic [15:0] expData, input string name);
        int startWe;
        int edges;
        bit seen;
        startWe   = weCount;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = ~addr;
        req_wdata = 16'hDEAD;
        checkOutput({name, "_issue_addr"}, {16'd0, mem_addr}, {16'd0, addr});
        checkOutput({name, "_issue_we"}, {31'd0, mem_we}, {31'd0, we});
        if (we) checkOutput({name, "_issue_din"}, {16'd0, mem_din}, {16'd0, wdata});
        edges = 0;
        seen  = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(posedge clk);
            #1;
            edges++;
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checkOutput({name, "_rsp_timeout"}, 32'd0, 32'd1);
        end else begin
            checkOutput({name, "_latency"}, edges, 32'd2);
            checkOutput({name, "_rdata"}, {16'd0, rsp_rdata}, {16'd0, expData});
        end
        @(posedge clk);
        #1;
        checkOutput({name, "_ready_back"}, {31'd0, req_ready}, 32'd1);
        checkOutput({name, "_we_pulses"}, weCount - startWe, we ? 32'd1 : 32'd0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    // Directed sequence
    initial begin
        int startWe;
        bit seen;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        sw_in     = 16'h00A5;
        for (int i = 0; i < 65536; i++) begin
            mem[i]    <= '0;
            shadow[i] <= '0;
        end
        mem[16'h0010]    <= 16'hBEEF;
        shadow[16'h0010] <= 16'hBEEF;
        mem[16'h4000]    <= 16'h0F0F;
        shadow[16'h4000] <= 16'h0F0F;
        mem[16'h0030]    <= 16'h5555;
        shadow[16'h0030] <= 16'h5555;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rst_mem_we",    {31'd0, mem_we},    32'd0);
        checkOutput("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
        checkOutput("rst_mem_addr",  {16'd0, mem_addr},  32'd0);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] read, write, read-back");
        applyStimulus(1'b0, 16'h0010, 16'h0000, 16'hBEEF, "read_0010");
        applyStimulus(1'b1, 16'h0020, 16'h1234, 16'h1234, "write_0020");
        checkOutput("mem_0020_written", {16'd0, mem[16'h0020]}, 32'h1234);
        applyStimulus(1'b0, 16'h0020, 16'h0000, 16'h1234, "read_0020");

        $display("[TB] IO accesses");
`ifdef MEM_MASTER_IO_READ_EN
        applyStimulus(1'b0, 16'h4000, 16'h0000, 16'h00A5, "io_read_4000");
`else
        applyStimulus(1'b0, 16'h4000, 16'h0000, 16'h0F0F, "io_read_4000");
`endif
        applyStimulus(1'b1, 16'h4004, 16'hCAFE, 16'hCAFE, "io_write_4004");
        checkOutput("mem_4004_written", {16'd0, mem[16'h4004]}, 32'hCAFE);

        $display("[TB] backpressure");
        startWe   = weCount;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 16'h0040;
        req_wdata = 16'h7777;
        @(posedge clk);
        #1;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
        if (!seen) checkOutput("bp_rsp_timeout", 32'd0, 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            checkOutput("bp_rsp_rdata", {16'd0, rsp_rdata}, 32'h7777);
            checkOutput("bp_req_ready", {31'd0, req_ready}, 32'd0);
        end
        checkOutput("bp_we_pulses", weCount - startWe, 32'd1);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput("bp_release_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;

        $display("[TB] reset during ISSUE of a write");
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 16'h0030;
        req_wdata = 16'h9999;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput("abort_we_before", {31'd0, mem_we}, 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("abort_we_after",  {31'd0, mem_we},    32'd0);
        checkOutput("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("abort_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("abort_mem_0030", {16'd0, mem[16'h0030]}, 32'h5555);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 16'h0030, 16'h0000, 16'h5555, "read_0030");

        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
